// File: rtl/dither_multi_ch.sv
// Per-channel colour quantiser: bypass, truncate, 4x4 ordered dither or 1-D error diffusion.
// Latency: exactly one clk cycle from data_in/visible to data_out/visible_out.
// Backpressure: none; accepts and emits one pixel every cycle.
module dither_multi_ch #(
    parameter int NUM_CH = 3,
    parameter int IN_W   = 8,
    parameter int OUT_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*IN_W-1:0]   data_in,
    input  logic                     visible,
    input  logic [1:0]               x_lsb,
    input  logic [1:0]               y_lsb,
    input  logic [1:0]               mode,
    output logic [NUM_CH*IN_W-1:0]   data_out,
    output logic                     visible_out
);

    // Number of bits dropped per channel.
    localparam int D = IN_W - OUT_W;

    localparam logic [1:0] MODE_BYPASS = 2'd0;
    localparam logic [1:0] MODE_TRUNC  = 2'd1;
    localparam logic [1:0] MODE_ORDER  = 2'd2;
    localparam logic [1:0] MODE_DIFF   = 2'd3;

    logic [3:0]      bayer;
    logic [IN_W-1:0] thresh;

    // 4x4 Bayer matrix lookup, shared by all channels.
    always_comb begin
        bayer = 4'd0;
        case ({y_lsb, x_lsb})
            4'h0: bayer = 4'd0;
            4'h1: bayer = 4'd8;
            4'h2: bayer = 4'd2;
            4'h3: bayer = 4'd10;
            4'h4: bayer = 4'd12;
            4'h5: bayer = 4'd4;
            4'h6: bayer = 4'd14;
            4'h7: bayer = 4'd6;
            4'h8: bayer = 4'd3;
            4'h9: bayer = 4'd11;
            4'hA: bayer = 4'd1;
            4'hB: bayer = 4'd9;
            4'hC: bayer = 4'd15;
            4'hD: bayer = 4'd7;
            4'hE: bayer = 4'd13;
            default: bayer = 4'd5;
        endcase
    end

    // Scale the 4-bit Bayer value so it spans the D dropped bits.
    generate
        if (D <= 4) begin : g_thr_shr
            logic [3:0] bayer_sh;
            assign bayer_sh = bayer >> (4 - D);
            assign thresh   = IN_W'(bayer_sh);
        end else begin : g_thr_shl
            assign thresh = {{(IN_W-4){1'b0}}, bayer} << (D - 4);
        end
    endgenerate

    // Registered visibility flag travels alongside the pixel.
    always_ff @(posedge clk) begin
        if (!rst) begin
            visible_out <= 1'b0;
        end else begin
            visible_out <= visible;
        end
    end

    genvar k;
    generate
        for (k = 0; k < NUM_CH; k++) begin : g_ch
            logic [IN_W-1:0]  din;
            logic [D-1:0]     err;
            logic [D-1:0]     err_nxt;
            logic [IN_W:0]    s_ord;
            logic [IN_W:0]    s_ed;
            logic [OUT_W-1:0] q_ord;
            logic [OUT_W-1:0] q_ed;
            logic [IN_W-1:0]  out_nxt;
            logic [IN_W-1:0]  out_q;

            assign din = data_in[k*IN_W +: IN_W];
            assign data_out[k*IN_W +: IN_W] = out_q;

            // Quantise this channel and compute the diffused residual for the next pixel.
            always_comb begin
                s_ord   = {1'b0, din} + {1'b0, thresh};
                s_ed    = {1'b0, din} + (IN_W+1)'(err);
                q_ord   = s_ord[IN_W] ? {OUT_W{1'b1}} : s_ord[IN_W-1:D];
                q_ed    = s_ed[IN_W]  ? {OUT_W{1'b1}} : s_ed[IN_W-1:D];
                // Residual is only carried across consecutive visible mode-3 pixels;
                // on saturation it is dropped so a bright run cannot wind up the error.
                err_nxt = '0;
                if (mode == MODE_DIFF && visible && !s_ed[IN_W]) begin
                    err_nxt = s_ed[D-1:0];
                end
                out_nxt = '0;
                case (mode)
                    MODE_BYPASS: out_nxt = din;
                    MODE_TRUNC:  out_nxt = visible ? {din[IN_W-1:D], {D{1'b0}}} : '0;
                    MODE_ORDER:  out_nxt = visible ? {q_ord, {D{1'b0}}} : '0;
                    default:     out_nxt = visible ? {q_ed, {D{1'b0}}} : '0;
                endcase
            end

            // Output pixel and error register for this channel.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    out_q <= '0;
                    err   <= '0;
                end else begin
                    out_q <= out_nxt;
                    err   <= err_nxt;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_dither_multi_ch.sv
// Scoreboard bench for dither_multi_ch with default parameters (3 x 8-bit, 4 kept bits).
// Driver pushes hand-computed expected outputs; monitor pops one per cycle after the edge.
// No backpressure in the DUT, so every driven cycle yields exactly one checked output.
module tb_dither_multi_ch;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] data_in;
    logic        visible;
    logic [1:0]  x_lsb;
    logic [1:0]  y_lsb;
    logic [1:0]  mode;
    logic [23:0] data_out;
    logic        visible_out;

    typedef struct {
        logic [23:0] dat;
        logic        vis;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    dither_multi_ch #(.NUM_CH(3), .IN_W(8), .OUT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .visible     (visible),
        .x_lsb       (x_lsb),
        .y_lsb       (y_lsb),
        .mode        (mode),
        .data_out    (data_out),
        .visible_out (visible_out)
    );

    // Drive one pixel at the falling edge and record what must appear after the next rising edge.
    task automatic step(input logic r, input logic [23:0] d, input logic v,
                        input logic [1:0] x, input logic [1:0] y, input logic [1:0] m,
                        input logic [23:0] ed, input logic ev, input string nm);
        exp_t e;
        @(negedge clk);
        rst     = r;
        data_in = d;
        visible = v;
        x_lsb   = x;
        y_lsb   = y;
        mode    = m;
        e.dat   = ed;
        e.vis   = ev;
        e.name  = nm;
        sb.push_back(e);
    endtask

    // Monitor: one output per cycle, compared against the oldest expectation.
    always @(posedge clk) begin : mon
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if (data_out !== e.dat) begin
                bad++;
                $display("FAIL %s data_out: got %06h want %06h", e.name, data_out, e.dat);
            end
            total++;
            if (visible_out !== e.vis) begin
                bad++;
                $display("FAIL %s visible_out: got %0b want %0b", e.name, visible_out, e.vis);
            end
        end
    end

    initial begin
        rst = 1'b0; data_in = '0; visible = 1'b0; x_lsb = '0; y_lsb = '0; mode = '0;

        // Reset holds outputs at zero even with a bright visible mode-3 input.
        step(0, 24'hFFFFFF, 1, 0, 0, 3, 24'h000000, 0, "rst0");
        step(0, 24'hFFFFFF, 1, 0, 0, 3, 24'h000000, 0, "rst1");
        step(1, 24'h080808, 1, 0, 0, 3, 24'h000000, 1, "post_rst");

        // Bypass ignores visible; truncate keeps top nibble and blanks.
        step(1, 24'h123456, 0, 0, 0, 0, 24'h123456, 0, "bypass");
        step(1, 24'h3A7F09, 1, 0, 0, 1, 24'h307000, 1, "trunc");
        step(1, 24'h3A7F09, 0, 0, 0, 1, 24'h000000, 0, "trunc_blank");

        // Ordered dither on ch0.
        step(1, 24'h000038, 1, 1, 0, 2, 24'h000040, 1, "ord_x1y0");
        step(1, 24'h000038, 1, 0, 0, 2, 24'h000030, 1, "ord_x0y0");
        step(1, 24'h0000FF, 1, 0, 3, 2, 24'h0000F0, 1, "ord_sat");
        step(1, 24'h000038, 1, 2, 1, 2, 24'h000040, 1, "ord_x2y1");
        step(1, 24'h000038, 0, 1, 0, 2, 24'h000000, 0, "ord_blank");

        // Error diffusion: constant 0x08 alternates 0x00 / 0x10.
        step(1, 24'h000008, 0, 0, 0, 3, 24'h000000, 0, "ed_pre");
        step(1, 24'h000008, 1, 0, 0, 3, 24'h000000, 1, "ed0");
        step(1, 24'h000008, 1, 0, 0, 3, 24'h000010, 1, "ed1");
        step(1, 24'h000008, 1, 0, 0, 3, 24'h000000, 1, "ed2");
        step(1, 24'h000008, 1, 0, 0, 3, 24'h000010, 1, "ed3");
        step(1, 24'h000008, 1, 0, 0, 3, 24'h000000, 1, "ed4");
        step(1, 24'h000008, 0, 0, 0, 3, 24'h000000, 0, "ed_blank");
        step(1, 24'h000008, 1, 0, 0, 3, 24'h000000, 1, "ed_resume0");
        step(1, 24'h000008, 1, 0, 0, 3, 24'h000010, 1, "ed_resume1");

        // Saturation drops the residual.
        step(1, 24'h000000, 0, 0, 0, 3, 24'h000000, 0, "sat_pre");
        step(1, 24'h000008, 1, 0, 0, 3, 24'h000000, 1, "sat0");
        step(1, 24'h0000FC, 1, 0, 0, 3, 24'h0000F0, 1, "sat1");
        step(1, 24'h000000, 1, 0, 0, 3, 24'h000000, 1, "sat2");

        // Channel independence and restart after leaving mode 3.
        step(1, 24'h001808, 0, 0, 0, 3, 24'h000000, 0, "ind_pre");
        step(1, 24'h001808, 1, 0, 0, 3, 24'h001000, 1, "ind0");
        step(1, 24'h001808, 1, 0, 0, 3, 24'h002010, 1, "ind1");
        step(1, 24'h001808, 1, 0, 0, 1, 24'h001000, 1, "ind_trunc");
        step(1, 24'h001808, 1, 0, 0, 3, 24'h001000, 1, "ind_re0");
        step(1, 24'h001808, 1, 0, 0, 3, 24'h002010, 1, "ind_re1");

        // Reset mid-line discards accumulated error.
        step(1, 24'h000008, 1, 0, 0, 3, 24'h000000, 1, "mid0");
        step(0, 24'h000008, 1, 0, 0, 3, 24'h000000, 0, "mid_rst");
        step(1, 24'h000008, 1, 0, 0, 3, 24'h000000, 1, "mid_after");

        // Let the monitor drain the scoreboard, bounded.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog against any unexpected stall of the stimulus thread.
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
